chave_programavel: RTL
======================

CHAVE_PROGRAMAVEL -- requirements
Module: chave_programavel

Interface
REQ-001 The block SHALL expose parameter SYM_BITS, default 1, meaning the width of one code symbol.
REQ-002 The block SHALL expose parameter CODE_LEN, default 4, meaning the number of symbols in the code (legal values 2..16).
REQ-003 The block SHALL expose parameter DEFAULT_CODE, default 4'b1101, width CODE_LEN*SYM_BITS, meaning the reset code; symbol i occupies bits [i*SYM_BITS +: SYM_BITS], and symbol 0 is entered first (default sequence 1,0,1,1).
REQ-004 The block SHALL expose parameter MAX_TRIES, default 3, meaning the number of failed attempts that triggers lockout.
REQ-005 The block SHALL expose parameter LOCK_CYCLES, default 8, meaning the duration of lockout in clock cycles.
REQ-006 The block SHALL have port clk_2, input, 1 bit, the single clock; all state changes occur on its rising edge.
REQ-007 The block SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-008 The block SHALL have port sym_valid, input, 1 bit, which qualifies sym for one cycle.
REQ-009 The block SHALL have port sym, input, SYM_BITS bits, the entered symbol.
REQ-010 The block SHALL have port lock_req, input, 1 bit, a relock request.
REQ-011 The block SHALL have port prog_req, input, 1 bit, a request to enter reprogramming.
REQ-012 The block SHALL have port ok, output, 1 bit, high while UNLOCKED.
REQ-013 The block SHALL have port locked_out, output, 1 bit, high while LOCKOUT.
REQ-014 The block SHALL have port prog_active, output, 1 bit, high while PROG.
REQ-015 The block SHALL have port idx, output, $clog2(CODE_LEN+1) bits, giving the count of symbols matched or stored.
REQ-016 The block SHALL have port tries, output, $clog2(MAX_TRIES+1) bits, giving the failed-attempt count.
REQ-017 The block SHALL have port seg, output, 8 bits, the seven-segment state glyph.

Function
REQ-018 The state machine SHALL have the states IDLE, UNLOCKED, PROG and LOCKOUT; ok, locked_out and prog_active SHALL be registered decodes of the state.
REQ-019 In IDLE, a cycle with sym_valid=1 and sym equal to code[idx] SHALL increment idx; when the matched symbol is code[CODE_LEN-1], the next state SHALL be UNLOCKED, with idx=0 and tries=0.
REQ-020 In IDLE, a sym_valid=1 mismatch at idx>0 SHALL count as a failed attempt: tries increments, and idx becomes 1 if sym equals code[0], otherwise 0.
REQ-021 In IDLE, a sym_valid=1 mismatch at idx=0 SHALL leave both idx and tries unchanged.
REQ-022 When a failed attempt brings tries to MAX_TRIES, the next state SHALL be LOCKOUT, with idx=0 and the lock counter loaded with LOCK_CYCLES.
REQ-023 In LOCKOUT, all inputs SHALL be ignored.
REQ-024 LOCKOUT SHALL last exactly LOCK_CYCLES cycles with locked_out=1, and SHALL then go to IDLE with tries=0.
REQ-025 In UNLOCKED, lock_req=1 SHALL go to IDLE; otherwise prog_req=1 SHALL go to PROG with idx=0; lock_req takes priority over prog_req.
REQ-026 In UNLOCKED, sym_valid SHALL be ignored.
REQ-027 In PROG, each sym_valid=1 SHALL write sym into the pending code slot idx and increment idx.
REQ-028 After the CODE_LEN-th symbol, the pending code SHALL be copied to the active code and the next state SHALL be UNLOCKED with idx=0.
REQ-029 lock_req=1 in PROG SHALL abort: the next state is IDLE, the active code is unchanged, and idx=0.
REQ-030 A sym_valid=1 in the same cycle as lock_req=1 in PROG SHALL NOT be stored.
REQ-031 A new code SHALL take effect only on the first sym_valid after the block returns to IDLE.
REQ-032 seg SHALL show 8'b00111111 in IDLE, 8'b01110111 in UNLOCKED, 8'b01110011 in PROG and 8'b00111000 in LOCKOUT.

Reset
REQ-033 When reset=1 at a clock edge, the block SHALL set state=IDLE, idx=0, tries=0, the lock counter to 0, and the active and pending code to DEFAULT_CODE.
REQ-034 In the cycle after reset, outputs SHALL be ok=0, locked_out=0, prog_active=0 and seg=8'b00111111.
REQ-035 reset SHALL override every other input in every state, including mid-LOCKOUT and mid-PROG; a reprogrammed code SHALL be lost on reset.

Verification
REQ-036 A bench SHALL check that with default parameters, sym 1,0,1,1 on consecutive valid cycles -> ok=1 the cycle after the 4th symbol, tries=0 and seg=8'b01110111.
REQ-037 A bench SHALL check that sequences 1,1 / 1,1 / 1,1 (three mismatches at idx=1) -> tries steps 1,2,3, locked_out=1 for exactly 8 cycles, and correct-code symbols sent during lockout are ignored.
REQ-038 A bench SHALL check that sequence 1,0,0 -> tries=1 and idx=0, and that a following 1,0,1,1 unlocks.
REQ-039 A bench SHALL check that unlock, then prog_req, then entry of 0,0,1,1, then lock_req -> old code 1,0,1,1 is rejected and 0,0,1,1 unlocks.
REQ-040 A bench SHALL check that lock_req and prog_req asserted together in UNLOCKED -> IDLE, with prog_active never high.
REQ-041 A bench SHALL check that reset asserted in PROG after 2 stored symbols and in LOCKOUT at cycle 3 -> IDLE, tries=0, and the code reverts to 1,0,1,1.

Source files
------------

// File: rtl/chave_programavel.sv
// chave_programavel -- programmable combination lock.
//
// A code of CODE_LEN symbols (SYM_BITS wide each) is entered one symbol per
// sym_valid cycle. A full correct code unlocks; MAX_TRIES failed attempts put
// the block into a timed lockout of LOCK_CYCLES cycles. While unlocked, the
// code can be reprogrammed. The new code only becomes active once all
// CODE_LEN symbols have been entered.
//
// Ports
//   clk_2       : clock, all state changes on its rising edge
//   reset       : synchronous active-high reset
//   sym_valid   : qualifies sym for one cycle
//   sym         : entered symbol
//   lock_req    : relock (UNLOCKED) / abort programming (PROG)
//   prog_req    : enter reprogramming from UNLOCKED
//   ok          : high while UNLOCKED
//   locked_out  : high while LOCKOUT
//   prog_active : high while PROG
//   idx         : symbols matched (IDLE) or stored (PROG)
//   tries       : failed-attempt count
//   seg         : seven-segment glyph for the current state
module chave_programavel #(
    parameter int SYM_BITS    = 1,
    parameter int CODE_LEN    = 4,
    parameter logic [CODE_LEN*SYM_BITS-1:0] DEFAULT_CODE = 4'b1101,
    parameter int MAX_TRIES   = 3,
    parameter int LOCK_CYCLES = 8
) (
    input  logic                               clk_2,
    input  logic                               reset,
    input  logic                               sym_valid,
    input  logic [SYM_BITS-1:0]                sym,
    input  logic                               lock_req,
    input  logic                               prog_req,
    output logic                               ok,
    output logic                               locked_out,
    output logic                               prog_active,
    output logic [$clog2(CODE_LEN+1)-1:0]      idx,
    output logic [$clog2(MAX_TRIES+1)-1:0]     tries,
    output logic [7:0]                         seg
);

    localparam int IW = $clog2(CODE_LEN+1);
    localparam int TW = $clog2(MAX_TRIES+1);
    localparam int CW = $clog2(LOCK_CYCLES+1);
    localparam int CB = CODE_LEN*SYM_BITS;

    localparam logic [7:0] SEG_IDLE     = 8'b00111111;
    localparam logic [7:0] SEG_UNLOCKED = 8'b01110111;
    localparam logic [7:0] SEG_PROG     = 8'b01110011;
    localparam logic [7:0] SEG_LOCKOUT  = 8'b00111000;

    typedef enum logic [1:0] {IDLE, UNLOCKED, PROG, LOCKOUT} state_t;

    state_t            r_state;
    logic [IW-1:0]     r_idx;
    logic [TW-1:0]     r_tries;
    logic [CW-1:0]     r_cnt;
    logic [CB-1:0]     r_code;
    logic [CB-1:0]     r_pend;
    logic              r_ok;
    logic              r_locked;
    logic              r_prog;
    logic [7:0]        r_seg;

    state_t            w_state_nxt;
    logic [IW-1:0]     w_idx_nxt;
    logic [TW-1:0]     w_tries_nxt;
    logic [CW-1:0]     w_cnt_nxt;
    logic [CB-1:0]     w_code_nxt;
    logic [CB-1:0]     w_pend_nxt;

    logic [SYM_BITS-1:0] w_cur_sym;
    logic [CB-1:0]       w_pend_wr;
    logic                w_match;
    logic                w_first;
    logic                w_last;
    logic [TW-1:0]       w_tries_inc;

    function automatic logic [7:0] seg_of(input state_t s);
        case (s)
            UNLOCKED: seg_of = SEG_UNLOCKED;
            PROG:     seg_of = SEG_PROG;
            LOCKOUT:  seg_of = SEG_LOCKOUT;
            default:  seg_of = SEG_IDLE;
        endcase
    endfunction

    // Symbol at position idx of the active code, and the pending code with
    // slot idx overwritten by sym. Constant-index loops keep every select
    // in range even if idx were ever out of bounds.
    always_comb begin
        w_cur_sym = '0;
        w_pend_wr = r_pend;
        for (int i = 0; i < CODE_LEN; i++) begin
            if (r_idx == IW'(i)) begin
                w_cur_sym = r_code[i*SYM_BITS +: SYM_BITS];
                w_pend_wr[i*SYM_BITS +: SYM_BITS] = sym;
            end
        end
    end

    assign w_match     = (sym == w_cur_sym);
    assign w_first     = (sym == r_code[SYM_BITS-1:0]);
    assign w_last      = (r_idx == IW'(CODE_LEN-1));
    assign w_tries_inc = r_tries + TW'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_tries_nxt = r_tries;
        w_cnt_nxt   = r_cnt;
        w_code_nxt  = r_code;
        w_pend_nxt  = r_pend;
        case (r_state)
            IDLE: begin
                if (sym_valid) begin
                    if (w_match) begin
                        if (w_last) begin
                            w_state_nxt = UNLOCKED;
                            w_idx_nxt   = '0;
                            w_tries_nxt = '0;
                        end else begin
                            w_idx_nxt = r_idx + IW'(1);
                        end
                    end else if (r_idx != '0) begin
                        // A wrong symbol mid-sequence is a failed attempt,
                        // but it may itself start a new attempt.
                        w_tries_nxt = w_tries_inc;
                        if (w_tries_inc == TW'(MAX_TRIES)) begin
                            w_state_nxt = LOCKOUT;
                            w_idx_nxt   = '0;
                            w_cnt_nxt   = CW'(LOCK_CYCLES);
                        end else begin
                            w_idx_nxt = w_first ? IW'(1) : '0;
                        end
                    end
                end
            end
            UNLOCKED: begin
                if (lock_req) begin
                    w_state_nxt = IDLE;
                    w_idx_nxt   = '0;
                end else if (prog_req) begin
                    w_state_nxt = PROG;
                    w_idx_nxt   = '0;
                end
            end
            PROG: begin
                // lock_req wins over a simultaneous symbol, which is dropped.
                if (lock_req) begin
                    w_state_nxt = IDLE;
                    w_idx_nxt   = '0;
                end else if (sym_valid) begin
                    w_pend_nxt = w_pend_wr;
                    if (w_last) begin
                        w_code_nxt  = w_pend_wr;
                        w_state_nxt = UNLOCKED;
                        w_idx_nxt   = '0;
                    end else begin
                        w_idx_nxt = r_idx + IW'(1);
                    end
                end
            end
            LOCKOUT: begin
                // Counter is loaded with LOCK_CYCLES on entry; leaving on the
                // count of 1 gives exactly LOCK_CYCLES cycles in this state.
                if (r_cnt <= CW'(1)) begin
                    w_state_nxt = IDLE;
                    w_tries_nxt = '0;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with r_state.
    always_ff @(posedge clk_2) begin
        if (reset) begin
            r_state  <= IDLE;
            r_idx    <= '0;
            r_tries  <= '0;
            r_cnt    <= '0;
            r_code   <= DEFAULT_CODE;
            r_pend   <= DEFAULT_CODE;
            r_ok     <= 1'b0;
            r_locked <= 1'b0;
            r_prog   <= 1'b0;
            r_seg    <= SEG_IDLE;
        end else begin
            r_state  <= w_state_nxt;
            r_idx    <= w_idx_nxt;
            r_tries  <= w_tries_nxt;
            r_cnt    <= w_cnt_nxt;
            r_code   <= w_code_nxt;
            r_pend   <= w_pend_nxt;
            r_ok     <= (w_state_nxt == UNLOCKED);
            r_locked <= (w_state_nxt == LOCKOUT);
            r_prog   <= (w_state_nxt == PROG);
            r_seg    <= seg_of(w_state_nxt);
        end
    end

    assign ok          = r_ok;
    assign locked_out  = r_locked;
    assign prog_active = r_prog;
    assign idx         = r_idx;
    assign tries       = r_tries;
    assign seg         = r_seg;

endmodule
